chess_clock_display_scan: RTL and testbench
===========================================

# chess_clock_display_scan

Time-multiplexed display driver sitting directly downstream of the chess clock top-level segment decoders. It consumes the four decoded 7-segment codes (two digits per player), the win flags and the active-player flags. It drives one shared segment bus plus four digit enables, so the clock can run on boards with a multiplexed 4-digit display. It adds anti-ghosting blanking, a 2 Hz blink for a winning player, and a decimal-point marker on the running player's clock.

## Interface
- p_SCAN_DIV, 50_000, clock cycles per digit slot (250 Hz per digit at 50 MHz); must be greater than p_BLANK.
- p_BLANK, 16, cycles at the start of each slot with all digits off; 0 is legal.
- p_BLINK_DIV, 12_500_000, cycles per blink half-period.
- i_clk_50mhz  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_sgmnt_player_a  in  [6:0] x [1:0]  player A digits; [0] is units, [1] is tens; active-low segments.
- i_sgmnt_player_b  in  [6:0] x [1:0]  player B digits, same format as player A.
- i_blink_a  in  1  flash player A digits (player A has won).
- i_blink_b  in  1  flash player B digits (player B has won).
- i_active_a  in  1  player A clock running; lights the decimal point on A tens.
- i_active_b  in  1  player B clock running; lights the decimal point on B tens.
- o_seg  out  [6:0]  shared segment bus, active-low.
- o_dp  out  1  shared decimal point, active-low.
- o_dig  out  [3:0]  digit enables, active-low, at most one low at a time.

## Operation
- Slot counter s runs 0..p_SCAN_DIV-1. When it wraps, digit index k advances 0→1→2→3→0.
- Slot mapping:
  - k=0: A units.
  - k=1: A tens.
  - k=2: B units.
  - k=3: B tens.
- Input sampling: in the cycle where s==0, the selected digit's code and the blink, active and phase state are sampled into a slot register. Input changes mid-slot are ignored until the next slot.
- Blanking window: while s < p_BLANK, o_dig=4'hF. Otherwise o_dig has only bit k low.
- Blink phase: a free-running counter toggles `phase` every p_BLINK_DIV cycles. Phase is 1 (visible) out of reset.
- Player blanked: if the slot's player has blink=1 and the sampled phase=0, o_seg=7'h7F and o_dp=1 for the whole slot. The digit enable still scans.
- Decimal point: o_dp=0 only in slots k=1 when i_active_a=1, and k=3 when i_active_b=1, unless that player is blanked.
- Both active flags high is legal; both decimal points light in their own slots. Both blink flags high blinks all four digits in the same phase.
- Arithmetic: counter widths are $clog2 of the divider. Counters wrap with no saturation.

## Timing
- All outputs are registered. Each output reflects the counter state of the previous cycle, i.e. one cycle of latency from s/k to the pins.
- Reset values:
  - o_seg=7'h7F, o_dp=1, o_dig=4'hF.
  - s=0, k=0, blink counter=0, phase=1.
- First cycle after reset release: s=0 for slot k=0, so inputs are sampled. o_dig[0] first goes low (p_BLANK+1) cycles after release.
- Reset asserted mid-slot: all outputs go to their reset values immediately (asynchronously). The scan restarts at k=0.
- The slot register updates on the same edge that o_dig goes to 4'hF. Segment data therefore changes only while all digits are off, provided p_BLANK≥1.
- Full scan period = 4·p_SCAN_DIV cycles.

## Structure
- Shared package chess_clock_pkg:
  - SEG_BLANK = 7'h7F.
  - N_DIGITS = 4.
  - Default divider constants for a 50 MHz clock.
  - Slot enum: SLOT_A0, SLOT_A1, SLOT_B0, SLOT_B1.
- One natural sub-module, scan_divider. It is a parameterised wrap counter with a terminal-count pulse, instantiated twice: once for the slot counter and once for the blink half-period.
- Top level contains the slot FSM (k), the slot register and the output registers.

## Test plan
Benches use p_SCAN_DIV=8, p_BLANK=2, p_BLINK_DIV=32.
- Reset with A={7'h40,7'h79}, B={7'h24,7'h30} and no flags → expected response:
  - Slots repeat every 32 cycles: o_dig 4'b1110, 1101, 1011, 0111.
  - o_seg for those slots: 7'h40, 7'h79, 7'h24, 7'h30.
  - o_dig=4'hF for 2 cycles at the start of each slot.
- Change i_sgmnt_player_a[0] from 7'h40 to 7'h12 at s=4 of slot 0 → o_seg stays 7'h40 until the slot ends; 7'h12 appears at the next slot-0 visit.
- i_blink_b=1 held → slots 2 and 3 show o_seg=7'h7F and o_dp=1 during phase-0 intervals, and normal codes during phase-1. Phase toggles every 32 cycles. Slots 0 and 1 are unaffected.
- i_active_a=1, i_active_b=0 → o_dp=0 only during slot 1 with its enable low. Then set i_active_b=1 → o_dp=0 in both slot 1 and slot 3.
- Assert i_rst at s=5 of slot 2 → same cycle: o_dig=4'hF, o_seg=7'h7F, o_dp=1. After release the scan restarts at slot 0 with phase=1.
- Throughout all scenarios, an assertion checks that o_dig never has more than one bit low, and never changes directly from one low bit to another without an all-high cycle between.

Source files
------------

// File: rtl/chess_clock_pkg.sv
// Shared constants and types for the chess clock display path.
package chess_clock_pkg;

  localparam int N_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Defaults for a 50 MHz system clock
  localparam int SCAN_DIV_DEFAULT  = 50_000;
  localparam int BLANK_DEFAULT     = 16;
  localparam int BLINK_DIV_DEFAULT = 12_500_000;

  typedef enum logic [1:0] {
    SLOT_A0,
    SLOT_A1,
    SLOT_B0,
    SLOT_B1
  } slot_e;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } slot_reg_t;

  function automatic logic [3:0] dig_enable_n(slot_e k);
    return ~(4'b0001 << k);
  endfunction

endpackage

// File: rtl/chess_clock_display_scan_if.sv
// Segment-code inputs and multiplexed display outputs of the scan driver.
interface chess_clock_display_scan_if;

  logic [1:0][6:0] i_sgmnt_player_a;
  logic [1:0][6:0] i_sgmnt_player_b;
  logic            i_blink_a;
  logic            i_blink_b;
  logic            i_active_a;
  logic            i_active_b;
  logic [6:0]      o_seg;
  logic            o_dp;
  logic [3:0]      o_dig;

  modport master (
    output i_sgmnt_player_a, i_sgmnt_player_b,
    output i_blink_a, i_blink_b, i_active_a, i_active_b,
    input  o_seg, o_dp, o_dig
  );

  modport slave (
    input  i_sgmnt_player_a, i_sgmnt_player_b,
    input  i_blink_a, i_blink_b, i_active_a, i_active_b,
    output o_seg, o_dp, o_dig
  );

endinterface

// File: rtl/scan_divider.sv
// Wrap counter 0..p_DIV-1 with a terminal-count flag on the last value.
module scan_divider #(
  parameter int p_DIV = 8,
  parameter int p_W   = $clog2(p_DIV)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  output logic [p_W-1:0] cnt_o,
  output logic           tc_o
);

  localparam logic [p_W-1:0] LAST = p_W'(p_DIV - 1);

  logic [p_W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = tc_o ? '0 : cnt_q + p_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chess_clock_display_scan.sv
// Multiplexed 4-digit scan driver for the chess clock: shared segment bus with
// per-slot blanking, win blink and a running-player decimal point.
//
// state   | meaning
// SLOT_A0 | player A units digit on the bus
// SLOT_A1 | player A tens digit (dp marks A running)
// SLOT_B0 | player B units digit
// SLOT_B1 | player B tens digit (dp marks B running)
module chess_clock_display_scan
  import chess_clock_pkg::*;
#(
  parameter int p_SCAN_DIV  = SCAN_DIV_DEFAULT,
  parameter int p_BLANK     = BLANK_DEFAULT,
  parameter int p_BLINK_DIV = BLINK_DIV_DEFAULT
) (
  input logic                       i_clk_50mhz,
  input logic                       i_rst,
  chess_clock_display_scan_if.slave bus
);

  localparam int SW = $clog2(p_SCAN_DIV);
  localparam int BW = $clog2(p_BLINK_DIV);
  localparam logic [SW-1:0] BLANK_END = SW'(p_BLANK);

  logic [SW-1:0] s;
  logic          slot_tc;
  logic [BW-1:0] blink_cnt_unused;
  logic          blink_tc;

  slot_e     k_q, k_d;
  logic      phase_q, phase_d;
  slot_reg_t slot_q, slot_d;
  logic [3:0] dig_q, dig_d;

  logic [6:0] code;
  logic       blink_sel;
  logic       active_sel;
  logic       blanked;

  scan_divider #(.p_DIV(p_SCAN_DIV)) u_slot_div (
    .clk_i (i_clk_50mhz),
    .rst_i (i_rst),
    .cnt_o (s),
    .tc_o  (slot_tc)
  );

  scan_divider #(.p_DIV(p_BLINK_DIV)) u_blink_div (
    .clk_i (i_clk_50mhz),
    .rst_i (i_rst),
    .cnt_o (blink_cnt_unused),
    .tc_o  (blink_tc)
  );

  // Slot FSM: state register
  always_ff @(posedge i_clk_50mhz or posedge i_rst) begin
    if (i_rst) begin
      k_q <= SLOT_A0;
    end else begin
      k_q <= k_d;
    end
  end

  // Slot FSM: next state, advances when the slot counter wraps
  always_comb begin
    k_d = k_q;
    if (slot_tc) begin
      unique case (k_q)
        SLOT_A0: k_d = SLOT_A1;
        SLOT_A1: k_d = SLOT_B0;
        SLOT_B0: k_d = SLOT_B1;
        SLOT_B1: k_d = SLOT_A0;
      endcase
    end
  end

  // Slot FSM: outputs. Blink state is folded into the sampled code so the
  // whole slot shows one consistent value regardless of later input changes.
  always_comb begin
    code       = SEG_BLANK;
    blink_sel  = 1'b0;
    active_sel = 1'b0;
    unique case (k_q)
      SLOT_A0: begin
        code      = bus.i_sgmnt_player_a[0];
        blink_sel = bus.i_blink_a;
      end
      SLOT_A1: begin
        code       = bus.i_sgmnt_player_a[1];
        blink_sel  = bus.i_blink_a;
        active_sel = bus.i_active_a;
      end
      SLOT_B0: begin
        code      = bus.i_sgmnt_player_b[0];
        blink_sel = bus.i_blink_b;
      end
      SLOT_B1: begin
        code       = bus.i_sgmnt_player_b[1];
        blink_sel  = bus.i_blink_b;
        active_sel = bus.i_active_b;
      end
    endcase

    blanked = blink_sel & ~phase_q;

    slot_d = slot_q;
    if (s == '0) begin
      slot_d.seg = blanked ? SEG_BLANK : code;
      slot_d.dp  = ~(active_sel & ~blanked);
    end

    dig_d = (s < BLANK_END) ? 4'hF : dig_enable_n(k_q);
  end

  assign phase_d = blink_tc ? ~phase_q : phase_q;

  always_ff @(posedge i_clk_50mhz or posedge i_rst) begin
    if (i_rst) begin
      phase_q <= 1'b1;
      slot_q  <= '{seg: SEG_BLANK, dp: 1'b1};
      dig_q   <= 4'hF;
    end else begin
      phase_q <= phase_d;
      slot_q  <= slot_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.o_seg = slot_q.seg;
  assign bus.o_dp  = slot_q.dp;
  assign bus.o_dig = dig_q;

endmodule

// File: tb/tb_chess_clock_display_scan.sv
// Directed bench for the display scan driver with a cycle-time reference model.
module tb_chess_clock_display_scan;

  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int BLINK = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  chess_clock_display_scan_if bus ();

  chess_clock_display_scan #(
    .p_SCAN_DIV  (SCAN),
    .p_BLANK     (BLANK),
    .p_BLINK_DIV (BLINK)
  ) dut (
    .i_clk_50mhz (clk),
    .i_rst       (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: outputs after edge n depend on time t = n-1 since reset release.
  int         ecount = 0;
  int         m_s, m_k;
  bit         m_vis, m_blink, m_act, m_off;
  logic [6:0] m_code;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp  = 1'b1;
  logic [3:0] m_dig = 4'hF;

  always @(posedge clk) begin
    if (rst) begin
      ecount = 0;
      m_seg  = 7'h7F;
      m_dp   = 1'b1;
      m_dig  = 4'hF;
    end else begin
      m_s   = ecount % SCAN;
      m_k   = (ecount / SCAN) % 4;
      m_vis = ((ecount / BLINK) % 2) == 0;
      if (m_s == 0) begin
        case (m_k)
          0:       m_code = bus.i_sgmnt_player_a[0];
          1:       m_code = bus.i_sgmnt_player_a[1];
          2:       m_code = bus.i_sgmnt_player_b[0];
          default: m_code = bus.i_sgmnt_player_b[1];
        endcase
        m_blink = (m_k < 2) ? bus.i_blink_a : bus.i_blink_b;
        m_act   = (m_k == 1 && bus.i_active_a) || (m_k == 3 && bus.i_active_b);
        m_off   = m_blink && !m_vis;
        m_seg   = m_off ? 7'h7F : m_code;
        m_dp    = !(m_act && !m_off);
      end
      m_dig  = (m_s < BLANK) ? 4'hF : ~(4'b0001 << m_k);
      ecount = ecount + 1;
    end
  end

  logic [3:0] prev_dig = 4'hF;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_seg", {1'b0, bus.o_seg}, 8'h7F);
      check("rst_dp",  {7'b0, bus.o_dp},  8'h01);
      check("rst_dig", {4'b0, bus.o_dig}, 8'h0F);
    end else begin
      check("model_seg", {1'b0, bus.o_seg}, {1'b0, m_seg});
      check("model_dp",  {7'b0, bus.o_dp},  {7'b0, m_dp});
      check("model_dig", {4'b0, bus.o_dig}, {4'b0, m_dig});
    end
    check("dig_one_low", {7'b0, ($countones(~bus.o_dig) <= 1)}, 8'h01);
    if (prev_dig != 4'hF && bus.o_dig != 4'hF)
      check("dig_no_direct_switch", {4'b0, bus.o_dig}, {4'b0, prev_dig});
    prev_dig = bus.o_dig;
  end

  task automatic go_to(input int n);
    do @(negedge clk); while (ecount < n);
  endtask

  task automatic pin(input string name, input logic [3:0] dig, input logic [6:0] seg,
                     input logic dp);
    check({name, "_dig"}, {4'b0, bus.o_dig}, {4'b0, dig});
    check({name, "_seg"}, {1'b0, bus.o_seg}, {1'b0, seg});
    check({name, "_dp"},  {7'b0, bus.o_dp},  {7'b0, dp});
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_sgmnt_player_a[0] = 7'h40;
    bus.i_sgmnt_player_a[1] = 7'h79;
    bus.i_sgmnt_player_b[0] = 7'h24;
    bus.i_sgmnt_player_b[1] = 7'h30;
    bus.i_blink_a  = 1'b0;
    bus.i_blink_b  = 1'b0;
    bus.i_active_a = 1'b0;
    bus.i_active_b = 1'b0;

    repeat (3) @(negedge clk);
    pin("reset", 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;

    go_to(1);   pin("first_sample", 4'hF, 7'h40, 1'b1);
    go_to(2);   pin("blank_end",    4'hF, 7'h40, 1'b1);
    go_to(3);   pin("slot0_on",     4'hE, 7'h40, 1'b1);
    go_to(10);  pin("slot1_blank",  4'hF, 7'h79, 1'b1);
    go_to(11);  pin("slot1_on",     4'hD, 7'h79, 1'b1);
    go_to(21);  pin("slot2",        4'hB, 7'h24, 1'b1);
    go_to(29);  pin("slot3",        4'h7, 7'h30, 1'b1);

    go_to(37);  bus.i_sgmnt_player_a[0] = 7'h12;
    go_to(40);  pin("midslot_hold", 4'hE, 7'h40, 1'b1);
    go_to(41);  pin("next_slot",    4'hF, 7'h79, 1'b1);
    go_to(67);  pin("new_code",     4'hE, 7'h12, 1'b1);

    bus.i_blink_b = 1'b1;
    go_to(85);  pin("blink_ph1_b0", 4'hB, 7'h24, 1'b1);
    go_to(101); pin("blink_a_unaff", 4'hE, 7'h12, 1'b1);
    go_to(117); pin("blink_ph0_b0", 4'hB, 7'h7F, 1'b1);
    go_to(125); pin("blink_ph0_b1", 4'h7, 7'h7F, 1'b1);
    go_to(149); pin("blink_ph1_again", 4'hB, 7'h24, 1'b1);
    bus.i_blink_b  = 1'b0;
    bus.i_active_a = 1'b1;

    go_to(165); pin("dp_slot0_off", 4'hE, 7'h12, 1'b1);
    go_to(173); pin("dp_a_on",      4'hD, 7'h79, 1'b0);
    go_to(189); pin("dp_b_off",     4'h7, 7'h30, 1'b1);
    bus.i_active_b = 1'b1;
    go_to(205); pin("dp_both_a",    4'hD, 7'h79, 1'b0);
    go_to(221); pin("dp_both_b",    4'h7, 7'h30, 1'b0);

    go_to(246); pin("pre_reset",    4'hB, 7'h24, 1'b1);
    #2 rst = 1'b1;
    bus.i_blink_a = 1'b1;
    #1 pin("async_reset", 4'hF, 7'h7F, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    go_to(1);  pin("restart_sample", 4'hF, 7'h12, 1'b1);
    go_to(3);  pin("restart_slot0",  4'hE, 7'h12, 1'b1);
    go_to(13); pin("restart_slot1",  4'hD, 7'h79, 1'b0);
    go_to(35); pin("win_a_ph0_u",    4'hE, 7'h7F, 1'b1);
    go_to(45); pin("win_a_ph0_dp",   4'hD, 7'h7F, 1'b1);
    go_to(61); pin("b_unaffected",   4'h7, 7'h30, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
